mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU instruction-cycle unit (port A) and a debug/loader port (port B).
- Sits between the requesters and the data RAM and drives the RAM's mem_addr / mem_data_o / mem_WE.
- Req/gnt/ack handshake per port; round-robin on contention; one memory access every 2 cycles.

Parameters:
MEM_ADDR_WIDTH, 8, data memory address width
MEM_DATA_WIDTH, 8, data memory word width

Ports:
clk  in  1  system clock, rising edge
arst_n  in  1  asynchronous active-low reset
a_req  in  1  port A request; hold high until a_gnt
a_we  in  1  port A write (1) / read (0)
a_addr  in  MEM_ADDR_WIDTH  port A address
a_wdata  in  MEM_DATA_WIDTH  port A write data
a_gnt  out  1  port A grant pulse (1 cycle)
a_ack  out  1  port A completion pulse (1 cycle)
a_rdata  out  MEM_DATA_WIDTH  port A read data; valid with a_ack of a read, held until next port-A read ack
b_req, b_we, b_addr, b_wdata, b_gnt, b_ack, b_rdata: same as port A, for port B
mem_addr  out  MEM_ADDR_WIDTH  RAM address
mem_data_o  out  MEM_DATA_WIDTH  RAM write data
mem_WE  out  1  RAM write enable
mem_data_i  in  MEM_DATA_WIDTH  RAM read data, combinational from mem_addr

Behaviour:
- Reset (arst_n low, async): state=IDLE; all outputs 0; last_owner=B, so A wins the first tie. Reset mid-access drops mem_WE immediately; no ack is issued.
- All outputs are registered.
- FSM states: IDLE, ACCESS.
- IDLE:
  - Samples a_req / b_req.
  - If none: stay in IDLE.
  - Else pick a winner: a single requester wins; if both, the port != last_owner wins.
  - Register mem_addr <= winner addr, mem_data_o <= winner wdata, mem_WE <= winner we, winner gnt <= 1, owner <= winner, last_owner <= winner, state <= ACCESS.
- ACCESS (exactly 1 cycle):
  - gnt is high and the RAM sees stable addr/data/WE.
  - RAM writes on the edge ending ACCESS.
  - On that edge: gnt <= 0, mem_WE <= 0, owner ack <= 1; if read, owner rdata <= mem_data_i. state <= IDLE.
  - mem_addr and mem_data_o keep their last values.
- Latency: req seen high in cycle N -> gnt in N+1 -> ack (and rdata) in N+2. Next grant is possible in N+3.
- Requester rule:
  - Attributes are captured only on the grant edge.
  - The requester deasserts req in the cycle gnt is high, or keeps it high to request again.
  - Req changing during ACCESS is ignored.
- Back-to-back from the same port with the other port idle: grants every 2 cycles.
- Both ports held requesting: grants strictly alternate A, B, A, B...
- Non-owner rdata is never modified; its ack stays 0.
- Widths: no arithmetic; address and data pass straight through.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: port A always wins when both request; last_owner is unused. Port B can starve; this is accepted for CPU-priority builds.
- Undefined: round-robin as above (default).

Test Plan:
- Reset: arst_n=0 mid-ACCESS with mem_WE=1 -> mem_WE, gnt, ack all 0 within the same cycle; state IDLE after release.
- Single write then read, port A:
  - a_req=1, we=1, addr=0x10, wdata=0x5A -> a_gnt in cycle 1, mem_WE=1 with mem_addr=0x10, a_ack in cycle 2.
  - Then a read of 0x10 -> a_ack with a_rdata=0x5A; b_ack stays 0.
- Contention after reset: a_req and b_req both held high with reads of 0x01 (A) and 0x02 (B) -> grant order A, B, A, B; a_rdata=mem[0x01], b_rdata=mem[0x02]; one grant per 2 cycles.
- Req timing: b_req pulses high for 1 cycle while A owns ACCESS -> ignored (not latched); b_req held across the next IDLE -> granted.
- rdata hold: port B read returns 0x33; then 3 port-A reads -> b_rdata stays 0x33 throughout.
- MEM_ARB_FIXED_PRIO_EN defined, both requesting continuously -> only A is granted for 10 grants; b_gnt=0 throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port req/gnt/ack arbiter in front of a single-port data RAM
//
// Port A (CPU) and port B (debug/loader) request with req, get a 1-cycle gnt
// while the RAM sees the access, then a 1-cycle ack (with rdata for reads).
// One access every 2 cycles; round-robin on contention.
// Build option MEM_ARB_FIXED_PRIO_EN: port A always wins a tie (B may starve).
//
// Ports:
//   clk, arst_n                       clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata         port A request and attributes
//   a_gnt/a_ack/a_rdata               port A grant, completion, read data
//   b_*                               same set for port B
//   mem_addr/mem_data_o/mem_WE        RAM address, write data, write enable
//   mem_data_i                        RAM read data (combinational from mem_addr)
module mem_arbiter #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      a_req,
    input  logic                      a_we,
    input  logic [MEM_ADDR_WIDTH-1:0] a_addr,
    input  logic [MEM_DATA_WIDTH-1:0] a_wdata,
    output logic                      a_gnt,
    output logic                      a_ack,
    output logic [MEM_DATA_WIDTH-1:0] a_rdata,
    input  logic                      b_req,
    input  logic                      b_we,
    input  logic [MEM_ADDR_WIDTH-1:0] b_addr,
    input  logic [MEM_DATA_WIDTH-1:0] b_wdata,
    output logic                      b_gnt,
    output logic                      b_ack,
    output logic [MEM_DATA_WIDTH-1:0] b_rdata,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_data_o,
    output logic                      mem_WE,
    input  logic [MEM_DATA_WIDTH-1:0] mem_data_i
);
    localparam logic IDLE   = 1'b0;
    localparam logic ACCESS = 1'b1;

    logic                      state_q, state_d;
    logic                      owner_q, owner_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                      mem_we_q, mem_we_d;
    logic                      a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic                      a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [MEM_DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                      pick_b;
    logic                      start;

    assign start = (state_q == IDLE) && (a_req || b_req);

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign pick_b = b_req && !a_req;
`else
    // last_owner: 0 = A, 1 = B; on a tie the port that did not go last wins
    logic last_q;
    assign pick_b = b_req && (!a_req || !last_q);
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) last_q <= 1'b1;
        else if (start) last_q <= pick_b;
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = mem_we_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        if (start) begin
            state_d    = ACCESS;
            owner_d    = pick_b;
            mem_addr_d = pick_b ? b_addr : a_addr;
            mem_data_d = pick_b ? b_wdata : a_wdata;
            mem_we_d   = pick_b ? b_we : a_we;
            a_gnt_d    = !pick_b;
            b_gnt_d    = pick_b;
        end else if (state_q == ACCESS) begin
            // the RAM commits a write on this edge; reads sample its output now
            state_d   = IDLE;
            mem_we_d  = 1'b0;
            a_ack_d   = !owner_q;
            b_ack_d   = owner_q;
            a_rdata_d = (!owner_q && !mem_we_q) ? mem_data_i : a_rdata_q;
            b_rdata_d = (owner_q && !mem_we_q) ? mem_data_i : b_rdata_q;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_gnt      = a_gnt_q;
    assign b_gnt      = b_gnt_q;
    assign a_ack      = a_ack_q;
    assign b_ack      = b_ack_q;
    assign a_rdata    = a_rdata_q;
    assign b_rdata    = b_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_WE     = mem_we_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a behavioural RAM
module tb_mem_arbiter;
    logic       clk, arst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_ack, b_gnt, b_ack, mem_WE;
    logic [7:0] a_rdata, b_rdata, mem_addr, mem_data_o, mem_data_i;
    logic [7:0] ram [256];

    typedef struct {
        logic       port;
        logic       rd;
        logic [7:0] data;
    } exp_t;
    exp_t sbq[$];
    int total = 0;
    int fails = 0;

    mem_arbiter #(.MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(8)) dut (
        .clk(clk), .arst_n(arst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_data_o(mem_data_o), .mem_WE(mem_WE),
        .mem_data_i(mem_data_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (mem_WE) ram[mem_addr] <= mem_data_o;
    assign mem_data_i = ram[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic rd, input logic [7:0] data);
        exp_t e;
        e.port = port;
        e.rd   = rd;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (a_ack || b_ack) begin
            if (sbq.size() == 0) chk("unexpected_ack", 32'(a_ack | b_ack), 32'd0);
            else begin
                e = sbq.pop_front();
                chk("ack_exclusive", 32'(a_ack & b_ack), 32'd0);
                chk("ack_port", 32'(b_ack), 32'(e.port));
                if (e.rd) chk(e.port ? "b_rdata" : "a_rdata", 32'(e.port ? b_rdata : a_rdata), 32'(e.data));
            end
        end
    endtask

    task automatic req_a(input logic we, input logic [7:0] addr, input logic [7:0] wd);
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic req_b(input logic we, input logic [7:0] addr, input logic [7:0] wd);
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    initial begin
        arst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        ram[8'h01] <= 8'h11;
        ram[8'h02] <= 8'h22;
        ram[8'h30] <= 8'h33;
        #1;
        chk("rst_a_gnt", 32'(a_gnt), 0);
        chk("rst_b_gnt", 32'(b_gnt), 0);
        chk("rst_acks", 32'({a_ack, b_ack}), 0);
        chk("rst_mem_WE", 32'(mem_WE), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_rdata", 32'({a_rdata, b_rdata}), 0);
        tick();
        tick();
        arst_n = 1'b1;

        req_a(1'b1, 8'h10, 8'h5A);
        push(1'b0, 1'b0, 8'h00);
        tick();
        chk("wr_a_gnt", 32'(a_gnt), 1);
        chk("wr_b_gnt", 32'(b_gnt), 0);
        chk("wr_mem_WE", 32'(mem_WE), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h10);
        chk("wr_mem_data", 32'(mem_data_o), 32'h5A);
        a_req = 1'b0;
        tick();
        chk("wr_a_ack", 32'(a_ack), 1);
        chk("wr_gnt_drop", 32'(a_gnt), 0);
        chk("wr_we_drop", 32'(mem_WE), 0);

        req_a(1'b0, 8'h10, 8'h00);
        push(1'b0, 1'b1, 8'h5A);
        tick();
        chk("rd_a_gnt", 32'(a_gnt), 1);
        chk("rd_mem_WE", 32'(mem_WE), 0);
        a_req = 1'b0;
        tick();
        chk("rd_a_ack", 32'(a_ack), 1);
        chk("rd_b_ack", 32'(b_ack), 0);

        req_a(1'b1, 8'h20, 8'h44);
        push(1'b0, 1'b0, 8'h00);
        tick();
        chk("rt_a_gnt", 32'(a_gnt), 1);
        a_req = 1'b0;
        req_b(1'b0, 8'h30, 8'h00);
        tick();
        b_req = 1'b0;
        chk("rt_b_gnt_access", 32'(b_gnt), 0);
        tick();
        chk("rt_pulse_ignored", 32'(b_gnt), 0);
        req_b(1'b0, 8'h30, 8'h00);
        push(1'b1, 1'b1, 8'h33);
        tick();
        chk("rt_b_gnt", 32'(b_gnt), 1);
        chk("rt_b_addr", 32'(mem_addr), 32'h30);
        b_req = 1'b0;
        tick();
        chk("rt_b_ack", 32'(b_ack), 1);

        for (int k = 0; k < 3; k++) begin
            req_a(1'b0, 8'h20, 8'h00);
            push(1'b0, 1'b1, 8'h44);
            tick();
            chk("hold_a_gnt", 32'(a_gnt), 1);
            a_req = 1'b0;
            tick();
            chk("hold_b_rdata", 32'(b_rdata), 32'h33);
            chk("hold_b_ack", 32'(b_ack), 0);
        end

        req_a(1'b1, 8'h40, 8'hEE);
        tick();
        chk("mid_mem_WE", 32'(mem_WE), 1);
        a_req = 1'b0;
        #1 arst_n = 1'b0;
        #1;
        chk("mid_rst_WE", 32'(mem_WE), 0);
        chk("mid_rst_gnt", 32'(a_gnt), 0);
        chk("mid_rst_ack", 32'(a_ack), 0);
        tick();
        chk("mid_rst_no_ack", 32'(a_ack), 0);
        arst_n = 1'b1;
        tick();
        chk("mid_rst_no_write", 32'(ram[8'h40]), 0);
        chk("mid_rst_idle", 32'({a_gnt, b_gnt}), 0);

`ifdef MEM_ARB_FIXED_PRIO_EN
        req_a(1'b0, 8'h01, 8'h00);
        req_b(1'b0, 8'h02, 8'h00);
        for (int k = 0; k < 10; k++) push(1'b0, 1'b1, 8'h11);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("fp_a_gnt", 32'(a_gnt), 32'(k % 2 == 1));
            chk("fp_b_gnt", 32'(b_gnt), 0);
            if (k == 19) begin a_req = 1'b0; b_req = 1'b0; end
        end
`else
        req_a(1'b0, 8'h01, 8'h00);
        req_b(1'b0, 8'h02, 8'h00);
        push(1'b0, 1'b1, 8'h11);
        push(1'b1, 1'b1, 8'h22);
        push(1'b0, 1'b1, 8'h11);
        push(1'b1, 1'b1, 8'h22);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("rr_a_gnt", 32'(a_gnt), 32'(k % 4 == 1));
            chk("rr_b_gnt", 32'(b_gnt), 32'(k % 4 == 3));
            if (k == 7) begin a_req = 1'b0; b_req = 1'b0; end
        end
`endif
        tick();
        chk("end_idle", 32'({a_gnt, b_gnt, a_ack, b_ack}), 0);
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
